// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_stall;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_stall
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage. One word access at a
// time, fixed LATENCY from acceptance to a one-cycle response pulse, with a
// stall output that freezes the pipeline while the access is outstanding.
//
// state | meaning
// IDLE  | ready for a request; captures it when req_valid is seen
// WAIT  | access in flight, count runs down towards the response cycle
// RESP  | resp_valid pulse; store committed / load data registered on entry
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 3,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // count never holds more than LATENCY-1
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT              state;
    logic [CNT_W-1:0]   count;
    logic               reqReady;
    logic               respValid;
    logic [31:0]        respRdata;
    logic               respErr;

    logic               capWrite;
    logic               capErr;
    logic [IDX_W-1:0]   capIdx;
    logic [31:0]        capWdata;

    logic [31:0]        storage [DEPTH_WORDS];

    logic [31:0]        liveOffset;
    logic [31:0]        liveWordOff;
    logic               liveErr;
    logic [IDX_W-1:0]   liveIdx;

    logic               selWrite;
    logic               selErr;
    logic [IDX_W-1:0]   selIdx;
    logic [31:0]        selWdata;
    logic               enterResp;
    logic               commitStore;
    logic [31:0]        loadData;

    // Decode the address currently on the bus; used at acceptance.
    always_comb begin
        liveOffset  = bus.req_addr - BASE_ADDR;
        liveWordOff = liveOffset >> 2;
        liveErr     = (bus.req_addr[1:0] != 2'b00)
                    | (bus.req_addr < BASE_ADDR)
                    | (liveWordOff >= DEPTH_WORDS);
        liveIdx     = liveWordOff[IDX_W-1:0];
    end

    // With LATENCY==1 the access goes straight from IDLE to RESP, so the live
    // bus fields stand in for the not-yet-captured ones.
    always_comb begin
        selWrite    = (state == IDLE) ? bus.req_write : capWrite;
        selErr      = (state == IDLE) ? liveErr       : capErr;
        selIdx      = (state == IDLE) ? liveIdx       : capIdx;
        selWdata    = (state == IDLE) ? bus.req_wdata : capWdata;
        enterResp   = reset & (((state == IDLE) & bus.req_valid & (LATENCY == 1))
                             | ((state == WAIT) & (count == CNT_W'(1))));
        commitStore = enterResp & selWrite & ~selErr;
        loadData    = (selWrite | selErr) ? 32'h0 : storage[selIdx];
    end

    // Storage array; not cleared by reset, written only on the edge entering RESP.
    always_ff @(posedge clock) begin
        if (commitStore) begin
            storage[selIdx] <= selWdata;
        end
    end

    // Access sequencer with registered handshake and response outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            reqReady  <= 1'b1;
            respValid <= 1'b0;
            respRdata <= 32'h0;
            respErr   <= 1'b0;
            capWrite  <= 1'b0;
            capErr    <= 1'b0;
            capIdx    <= '0;
            capWdata  <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    respValid <= 1'b0;
                    if (bus.req_valid) begin
                        capWrite <= bus.req_write;
                        capErr   <= liveErr;
                        capIdx   <= liveIdx;
                        capWdata <= bus.req_wdata;
                        reqReady <= 1'b0;
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            respValid <= 1'b1;
                            respRdata <= loadData;
                            respErr   <= selErr;
                        end else begin
                            state <= WAIT;
                            count <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state     <= RESP;
                        respValid <= 1'b1;
                        respRdata <= loadData;
                        respErr   <= selErr;
                    end
                end
                RESP: begin
                    // a req_valid still high here is the same access; ignore it
                    state     <= IDLE;
                    respValid <= 1'b0;
                    reqReady  <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    reqReady <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = reqReady;
    assign bus.resp_valid = respValid;
    assign bus.resp_rdata = respRdata;
    assign bus.resp_err   = respErr;
    // Low in RESP so the pipeline advances and latches resp_rdata that cycle.
    assign bus.mem_stall  = ((state == IDLE) & bus.req_valid) | (state == WAIT);
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: randomized and directed accesses, expectations
// from a word-array reference model pushed to a queue, checked by a monitor.
module tb_dmem_responder;
    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dmem_responder_if bus();

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT),
        .BASE_ADDR  (BASE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          dueEdge;
        string       tag;
    } expT;

    expT         expQ[$];
    logic [31:0] refMem [DEPTH];
    int          edgeCnt = 0;
    int          nChecks = 0;
    int          nPass   = 0;

    always @(posedge clock) edgeCnt <= edgeCnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act === req) nPass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    task automatic failNote(input string name, input string what);
        nChecks++;
        $display("FAIL %s: actual=%s required=event within bound", name, what);
    endtask

    // Reference decode: plain byte-address arithmetic.
    function automatic void refDecode(input logic [31:0] a, output bit err, output int idx);
        longint off;
        off = longint'({32'h0, a}) - longint'({32'h0, BASE});
        err = (a % 4 != 0) || (off < 0) || (off / 4 >= longint'(DEPTH));
        idx = err ? 0 : int'(off / 4);
    endfunction

    // Expected response for an access accepted at edge acc; updates the model.
    task automatic pushExpect(input bit w, input logic [31:0] a, input logic [31:0] d,
                              input int acc, input string tag);
        bit e;
        int idx;
        expT x;
        refDecode(a, e, idx);
        x.err     = e;
        x.rdata   = (e || w) ? 32'h0 : refMem[idx];
        // resp_valid rises on edge acc+LAT-1, i.e. it is high in cycle acc+LAT
        x.dueEdge = acc + int'(LAT) - 1;
        x.tag     = tag;
        expQ.push_back(x);
        if (!e && w) refMem[idx] = d;
    endtask

    // Monitor: every resp_valid pulse must match the oldest expectation.
    initial begin
        expT x;
        forever begin
            @(negedge clock);
            if (bus.resp_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    failNote("unexpected_resp", "resp_valid with nothing outstanding");
                end else begin
                    x = expQ.pop_front();
                    check({x.tag, "_rdata"}, bus.resp_rdata, x.rdata);
                    check({x.tag, "_err"}, {31'h0, bus.resp_err}, {31'h0, x.err});
                    check({x.tag, "_edge"}, edgeCnt, x.dueEdge);
                end
            end
        end
    end

    // One access; fields are scrambled while busy and valid is held into RESP.
    task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d, input string tag);
        int waitN = 0;
        int due;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (bus.req_ready !== 1'b1) begin
            if (waitN == 20) begin
                failNote({tag, "_accept"}, "req_ready stuck low");
                bus.req_valid = 1'b0;
                return;
            end
            @(negedge clock);
            waitN++;
        end
        pushExpect(w, a, d, edgeCnt + 1, tag);
        due = edgeCnt + int'(LAT);
        for (int k = 0; k < int'(LAT) + 4; k++) begin
            @(negedge clock);
            if (edgeCnt >= due) break;
            bus.req_write = 1'($urandom);
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
        check({tag, "_valid"}, {31'h0, bus.resp_valid}, 32'h0);
        check({tag, "_stall"}, {31'h0, bus.mem_stall}, 32'h0);
        check({tag, "_err"}, {31'h0, bus.resp_err}, 32'h0);
        check({tag, "_rdata"}, bus.resp_rdata, 32'h0);
    endtask

    // req_valid held continuously: each access occupies LAT+1 cycles, stall is
    // high for LAT of them and low in the response cycle.
    task automatic stallProfile(input logic [31:0] a, input int nReq);
        int phase;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = a;
        bus.req_wdata = 32'h0;
        for (int i = 0; i < nReq * (int'(LAT) + 1); i++) begin
            if (i > 0) @(negedge clock);
            #1;
            phase = i % (int'(LAT) + 1);
            if (phase == 0) pushExpect(1'b0, a, 32'h0, edgeCnt + 1, "hold");
            check("stall_profile", {31'h0, bus.mem_stall}, (phase != int'(LAT)) ? 32'h1 : 32'h0);
            check("ready_profile", {31'h0, bus.req_ready}, (phase == 0) ? 32'h1 : 32'h0);
        end
        bus.req_valid = 1'b0;
    endtask

    // Store to 0x20 with reset asserted while the access is in WAIT.
    task automatic abortedStore();
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h1234_5678;
        check("abort_ready", {31'h0, bus.req_ready}, 32'h1);
        @(negedge clock);
        bus.req_valid = 1'b0;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check("abort_no_resp", {31'h0, bus.resp_valid}, 32'h0);
        end
        checkResetState("abort_reset");
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("abort_no_resp_after", {31'h0, bus.resp_valid}, 32'h0);
        end
    endtask

    function automatic logic [31:0] randAddr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel <= 6) return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        if (sel == 7) return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        if (sel == 8) return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
        return $urandom;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int drainN;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkResetState("reset");
        reset = 1'b1;

        // Give every word a known value.
        for (int i = 0; i < int'(DEPTH); i++) begin
            access(1'b1, BASE + 32'(4 * i), $urandom, "init");
        end

        access(1'b1, 32'h10, 32'hDEAD_BEEF, "st10");
        access(1'b0, 32'h10, 32'h0, "ld10");
        access(1'b0, 32'h12, 32'h0, "ld_mis");
        access(1'b1, 32'h13, 32'hFFFF_FFFF, "st_mis");
        access(1'b0, 32'h10, 32'h0, "reld10");
        access(1'b0, 32'h400, 32'h0, "ld_oor");
        access(1'b0, 32'h3FC, 32'h0, "ld_last");
        access(1'b1, 32'h3FC, 32'hA5A5_0001, "st_last");
        access(1'b0, 32'h3FC, 32'h0, "reld_last");
        access(1'b0, 32'hFFFF_FFFC, 32'h0, "ld_top");

        stallProfile(32'h10, 3);

        abortedStore();
        access(1'b0, 32'h20, 32'h0, "ld20_after_abort");

        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            access(1'($urandom), randAddr(), $urandom, "rnd");
        end

        drainN = 0;
        while (expQ.size() != 0 && drainN < 20) begin
            @(negedge clock);
            drainN++;
        end
        check("queue_drained", expQ.size(), 32'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
